// File: rtl/dk_mix_pkg.sv
// ---------------------------------------------------------------------------
// dk_mix_pkg
// Shared constants, the mixer state enum and the 16-bit saturation helper
// used by dk_sound_mixer and dk_mix_dc_block.
//
// Build option: DK_MIX_DCBLOCK_EN adds the ST_DCB state used by the
// optional DC-blocking output filter.
// ---------------------------------------------------------------------------
package dk_mix_pkg;

    localparam int NUM_CH = 4;   // walk, jump, stomp, music DAC
    localparam int GAIN_W = 9;   // unsigned Q8 gain, 256 = 1.0
    localparam int ACC_W  = 27;  // 4 x (16b signed * 9b unsigned) + headroom

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
`ifdef DK_MIX_DCBLOCK_EN
        ,
        ST_DCB  = 2'd3
`endif
    } mix_state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [15:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dk_mix_dc_block.sv
// ---------------------------------------------------------------------------
// dk_mix_dc_block
// First-order DC-blocking filter applied to the mixed sample:
//     y = x - x_prev + y_prev - (y_prev >>> 8)
// evaluated in 17 bits, saturated to 16 bits. One sample per en pulse.
//
// Ports:
//   clk     system clock
//   I_RSTn  asynchronous active-low reset (clears history and output)
//   en      one-cycle strobe: consume in, update out and history
//   in      signed 16-bit input sample (saturated mixer sum)
//   out     signed 16-bit filtered sample, registered
// ---------------------------------------------------------------------------
module dk_mix_dc_block
    import dk_mix_pkg::*;
(
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               en,
    input  logic signed [15:0] in,
    output logic signed [15:0] out
);

    logic signed [15:0] x_prev_q;
    logic signed [15:0] y_prev_q;
    logic signed [15:0] out_q;
    logic signed [15:0] y_leak;
    logic signed [16:0] y_d;
    logic signed [15:0] y_sat;

    assign y_leak = y_prev_q >>> 8;

    assign y_d = {in[15], in} - {x_prev_q[15], x_prev_q}
               + {y_prev_q[15], y_prev_q} - {y_leak[15], y_leak};

    assign y_sat = sat16({{(ACC_W-17){y_d[16]}}, y_d});

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            out_q    <= '0;
        end else if (en) begin
            x_prev_q <= in;
            y_prev_q <= y_sat;   // history keeps the saturated output
            out_q    <= y_sat;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/dk_sound_mixer.sv
// ---------------------------------------------------------------------------
// dk_sound_mixer
// Four-channel sound mixer. On each audio_clk_en strobe the four channel
// inputs are snapshotted, multiplied by per-channel Q8 gains and summed
// serially (one channel per clock), then shifted down by 8, clamped to
// 16 bits and presented on out with a one-cycle out_valid pulse.
// Latency from the strobe edge is 5 clocks (6 with the DC blocker).
//
// Build option: DK_MIX_DCBLOCK_EN routes the saturated sum through
// dk_mix_dc_block before it reaches out.
//
// Ports:
//   clk           system clock
//   I_RSTn        asynchronous active-low reset
//   audio_clk_en  one-cycle sample strobe
//   in_walk       channel 0, signed 16
//   in_jump       channel 1, signed 16
//   in_stomp      channel 2, signed 16
//   in_dac        channel 3, signed 16 (music DAC)
//   out           mixed sample, signed 16, registered, held between updates
//   out_valid     one-cycle pulse when out updates
//   busy          high while a mix is in progress
//   overrun       one-cycle pulse when a strobe arrives while busy
// ---------------------------------------------------------------------------
module dk_sound_mixer
    import dk_mix_pkg::*;
#(
    parameter int CLOCK_RATE  = 1000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int GAIN0       = 256,
    parameter int GAIN1       = 256,
    parameter int GAIN2       = 256,
    parameter int GAIN3       = 256
) (
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in_walk,
    input  logic signed [15:0] in_jump,
    input  logic signed [15:0] in_stomp,
    input  logic signed [15:0] in_dac,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    // A mix occupies up to 6 clocks; strobes must be spaced further apart.
    generate
        if ((CLOCK_RATE / SAMPLE_RATE) < 7) begin : g_rate_check
            $error("dk_sound_mixer: CLOCK_RATE/SAMPLE_RATE must be at least 7");
        end
    endgenerate

    localparam int GAINS [NUM_CH] = '{GAIN0, GAIN1, GAIN2, GAIN3};

    logic        [GAIN_W-1:0] gain_tbl [NUM_CH];
    logic signed [15:0]       in_vec   [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_gain
            assign gain_tbl[gi] = GAIN_W'(GAINS[gi]);
        end
    endgenerate

    assign in_vec[0] = in_walk;
    assign in_vec[1] = in_jump;
    assign in_vec[2] = in_stomp;
    assign in_vec[3] = in_dac;

    mix_state_t               state_q;
    logic signed [15:0]       snap_q [NUM_CH];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic        [1:0]        idx_q;
    logic signed [15:0]       out_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    // Signed 16 x unsigned 9: zero-extend the gain to keep it positive.
    logic signed [15:0]       snap_sel;
    logic signed [GAIN_W:0]   gain_sel;
    logic signed [25:0]       prod;

    assign snap_sel = snap_q[idx_q];
    assign gain_sel = {1'b0, gain_tbl[idx_q]};
    assign prod     = snap_sel * gain_sel;
    assign acc_d    = acc_q + {{(ACC_W-26){prod[25]}}, prod};

`ifdef DK_MIX_DCBLOCK_EN
    logic signed [15:0] dcb_x_q;   // saturated sum handed to the filter
    logic signed [15:0] dcb_y;
`endif

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= ST_IDLE;
            snap_q      <= '{default: '0};
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DK_MIX_DCBLOCK_EN
            dcb_x_q     <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            // A strobe while a mix is running is dropped but flagged.
            overrun_q   <= audio_clk_en && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (audio_clk_en) begin
                        snap_q  <= in_vec;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACC;
                    end
                end

                ST_ACC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'(NUM_CH - 1)) begin
                        state_q <= ST_SAT;
                    end
                end

                ST_SAT: begin
`ifdef DK_MIX_DCBLOCK_EN
                    dcb_x_q     <= sat16(acc_q >>> 8);
                    state_q     <= ST_DCB;
`else
                    out_q       <= sat16(acc_q >>> 8);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
`endif
                end

`ifdef DK_MIX_DCBLOCK_EN
                ST_DCB: begin
                    // The filter registers its output on this same edge.
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
`endif

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DK_MIX_DCBLOCK_EN
    dk_mix_dc_block u_dc_block (
        .clk    (clk),
        .I_RSTn (I_RSTn),
        .en     (state_q == ST_DCB),
        .in     (dcb_x_q),
        .out    (dcb_y)
    );

    assign out = dcb_y;

    logic unused_out_q;
    assign unused_out_q = ^out_q;
`else
    assign out = out_q;
`endif

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dk_sound_mixer.sv
// ---------------------------------------------------------------------------
// tb_dk_sound_mixer
// Two mixer instances share the stimulus: dut_a with unity gains on every
// channel, dut_b with GAIN0 = 128 (0.5) and the other channels muted.
// Stimulus pushes hand-computed expected samples into per-instance queues;
// a monitor pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dk_sound_mixer;

`ifdef DK_MIX_DCBLOCK_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstn;
    logic               en;
    logic signed [15:0] w, j, s, d;

    logic signed [15:0] out_a, out_b;
    logic               va, vb, busy_a, busy_b, ovr_a, ovr_b;

    dk_sound_mixer #(
        .CLOCK_RATE(1000000), .SAMPLE_RATE(48000),
        .GAIN0(256), .GAIN1(256), .GAIN2(256), .GAIN3(256)
    ) dut_a (
        .clk(clk), .I_RSTn(rstn), .audio_clk_en(en),
        .in_walk(w), .in_jump(j), .in_stomp(s), .in_dac(d),
        .out(out_a), .out_valid(va), .busy(busy_a), .overrun(ovr_a)
    );

    dk_sound_mixer #(
        .CLOCK_RATE(1000000), .SAMPLE_RATE(48000),
        .GAIN0(128), .GAIN1(0), .GAIN2(0), .GAIN3(0)
    ) dut_b (
        .clk(clk), .I_RSTn(rstn), .audio_clk_en(en),
        .in_walk(w), .in_jump(j), .in_stomp(s), .in_dac(d),
        .out(out_b), .out_valid(vb), .busy(busy_b), .overrun(ovr_b)
    );

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_b[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every out_valid pulse consumes one expected sample.
    always @(negedge clk) begin
        if (va) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_valid", int'(va), 0);
            end else begin
                automatic int e = exp_a.pop_front();
                $display("TXN dut_a out=%0d expected=%0d", out_a, e);
                check("a_out", int'(out_a), e);
            end
        end
        if (vb) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_valid", int'(vb), 0);
            end else begin
                automatic int e = exp_b.pop_front();
                $display("TXN dut_b out=%0d expected=%0d", out_b, e);
                check("b_out", int'(out_b), e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        en   = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_a"},   int'(out_a), 0);
        check({tag, "_out_b"},   int'(out_b), 0);
        check({tag, "_valid_a"}, int'(va), 0);
        check({tag, "_busy_a"},  int'(busy_a), 0);
        check({tag, "_busy_b"},  int'(busy_b), 0);
        check({tag, "_ovr_a"},   int'(ovr_a), 0);
        check({tag, "_ovr_b"},   int'(ovr_b), 0);
    endtask

    // One strobe; inputs are scrambled at E1 so only the E0 snapshot counts.
    task automatic mix(input logic signed [15:0] a, b, c, e_in,
                       input int ea, input int eb);
        @(negedge clk);
        w = a; j = b; s = c; d = e_in;
        en = 1'b1;
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        @(posedge clk);                       // E0
        #1 en = 1'b0;
        check("busy_e0", int'(busy_a), 1);
        for (int k = 1; k < LAT; k++) begin   // E1..E(LAT-1)
            @(posedge clk);
            #1;
            if (k == 1) begin
                w = 16'sh7123; j = -16'sd4321; s = 16'sd999; d = -16'sd17;
            end
            check("busy_mid", int'(busy_a), 1);
            check("valid_early", int'(va), 0);
        end
        @(posedge clk);                       // E(LAT)
        #1;
        check("valid_at_lat_a", int'(va), 1);
        check("valid_at_lat_b", int'(vb), 1);
        check("busy_done", int'(busy_a), 0);
        check("ovr_none", int'(ovr_a), 0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0;
        w = '0; j = '0; s = '0; d = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("rst");

        // Basic mix and saturation vectors, fresh filter history each time.
        do_reset(); mix(16'sd1000, 16'sd2000, -16'sd500, 16'sd0, 2500, 500);
        do_reset(); mix(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 32767, 16383);
        do_reset(); mix(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -32768, -16384);
        do_reset(); mix(16'sd6826, 16'sd0, 16'sd0, 16'sd0, 6826, 3413);
        do_reset(); mix(-16'sd3, 16'sd0, 16'sd0, 16'sd0, -3, -2);

        // Constant input repeated: DC blocker decays, plain build holds.
        do_reset();
`ifdef DK_MIX_DCBLOCK_EN
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 10000, 5000);
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 9961, 4981);
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 9923, 4962);
`else
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 10000, 5000);
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 10000, 5000);
        mix(16'sd10000, 16'sd0, 16'sd0, 16'sd0, 10000, 5000);
`endif

        // Overrun: strobe at E0, inputs change at E1, second strobe at E2.
        do_reset();
        @(negedge clk);
        w = 16'sd1000; j = 16'sd2000; s = -16'sd500; d = 16'sd0;
        en = 1'b1;
        exp_a.push_back(2500);
        exp_b.push_back(500);
        @(posedge clk);                       // E0
        #1 en = 1'b0;
        @(posedge clk);                       // E1
        #1 w = 16'sd5; j = 16'sd6; s = 16'sd7; d = 16'sd8;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);                       // E2
        #1 en = 1'b0;
        check("overrun_pulse_a", int'(ovr_a), 1);
        check("overrun_pulse_b", int'(ovr_b), 1);
        @(posedge clk);                       // E3
        #1;
        check("overrun_clear", int'(ovr_a), 0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("overrun_busy_after", int'(busy_a), 0);

        // out holds between pulses.
        repeat (4) @(negedge clk);
        check("hold_a", int'(out_a), 2500);
        check("hold_b", int'(out_b), 500);

        // Reset mid-mix: outputs cleared, no out_valid afterwards.
        @(negedge clk);
        w = 16'sd1000; j = 16'sd1000; s = 16'sd1000; d = 16'sd1000;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        check_idle("postrst");

        check("a_pending", exp_a.size(), 0);
        check("b_pending", exp_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
